// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_pkg
//  Purpose  : Shared control-unit definitions for the instruction fetch stage:
//             fetch state encoding and instruction/address geometry.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

  localparam int INSTR_BYTES = 3;
  localparam int ADDR_WIDTH  = 16;
  localparam int INSTR_WIDTH = 24;
  localparam int BYTE_WIDTH  = 8;

  // Fetch sequencer states; width fixed explicitly at 3 bits.
  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_HOLD   = 3'd4
  } fetch_state_t;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_if
//  Purpose  : Bundles the fetch stage's MMU byte bus, redirect request and
//             decode-side valid/accept handshake.
//  Ports    : none; modports
//             master - fetch stage (drives mem_addr/mem_read/instruction*/pc)
//             slave  - environment (MMU, redirect source, decode stage)
//  Revision : 1.0 - initial release
// ============================================================================
interface if_stage_if;
  import if_stage_pkg::*;

  // MMU byte interface
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_read;
  logic                   mem_ready;
  logic [BYTE_WIDTH-1:0]  mem_data;
  // Redirect
  logic                   pc_load;
  logic [ADDR_WIDTH-1:0]  pc_value;
  // Decode handshake
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instruction_valid;
  logic                   instruction_accept;
  logic [ADDR_WIDTH-1:0]  pc;

  modport master (
    output mem_addr, mem_read,
    input  mem_ready, mem_data,
    input  pc_load, pc_value,
    output instruction, instruction_valid, pc,
    input  instruction_accept
  );

  modport slave (
    input  mem_addr, mem_read,
    output mem_ready, mem_data,
    output pc_load, pc_value,
    input  instruction, instruction_valid, pc,
    output instruction_accept
  );

endinterface : if_stage_if
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction fetch stage. Reads three consecutive bytes from the
//             MMU, assembles them big-endian (opcode byte first) and holds the
//             24-bit instruction for decode until accepted. The fetch address
//             can be redirected at any time by pc_load.
//  Ports    : clk   - system clock, rising edge
//             reset - asynchronous active-high reset
//             bus   - if_stage_if.master (MMU bus, redirect, decode handshake)
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
  input  wire logic   clk,
  input  wire logic   reset,
  if_stage_if.master  bus
);

  fetch_state_t           r_state;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_mem_read;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic                   r_valid;
  logic [ADDR_WIDTH-1:0]  r_pc;

  // All outputs come straight from registers: no input reaches mem_addr or
  // mem_read combinationally.
  assign bus.mem_addr          = r_addr;
  assign bus.mem_read          = r_mem_read;
  assign bus.instruction       = r_instr;
  assign bus.instruction_valid = r_valid;
  assign bus.pc                = r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_START;
      r_addr     <= RESET_VECTOR;
      r_mem_read <= 1'b0;
      r_instr    <= '0;
      r_valid    <= 1'b0;
      r_pc       <= RESET_VECTOR;
    end else if (bus.pc_load) begin
      // Redirect wins over mem_ready and instruction_accept: the byte on the
      // bus is dropped, partial bytes are abandoned, a held instruction is
      // invalidated. Instruction bytes themselves are left untouched.
      r_state    <= ST_FETCH0;
      r_addr     <= bus.pc_value;
      r_mem_read <= 1'b1;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          r_state    <= ST_FETCH0;
          r_mem_read <= 1'b1;
        end
        ST_FETCH0: begin
          if (bus.mem_ready) begin
            r_instr[INSTR_WIDTH-1 -: BYTE_WIDTH] <= bus.mem_data;
            r_pc   <= r_addr;
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_state <= ST_FETCH1;
          end
        end
        ST_FETCH1: begin
          if (bus.mem_ready) begin
            r_instr[2*BYTE_WIDTH-1 -: BYTE_WIDTH] <= bus.mem_data;
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_state <= ST_FETCH2;
          end
        end
        ST_FETCH2: begin
          if (bus.mem_ready) begin
            r_instr[BYTE_WIDTH-1:0] <= bus.mem_data;
            r_addr     <= r_addr + ADDR_WIDTH'(1);
            r_state    <= ST_HOLD;
            r_mem_read <= 1'b0;
            r_valid    <= 1'b1;
          end
        end
        ST_HOLD: begin
          // No prefetch: the bus stays idle until decode takes the word.
          if (bus.instruction_accept) begin
            r_state    <= ST_FETCH0;
            r_mem_read <= 1'b1;
            r_valid    <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_START;
          r_mem_read <= 1'b0;
          r_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule : if_stage
`default_nettype wire
